inst_fetch: RTL and testbench

Instruction fetch stage of the CPU. It owns the program counter and issues word reads to instruction memory over a req/ack handshake that tolerates variable latency. It presents each fetched instruction and its PC to decode (whose `inst` feeds the immediate generator) through a 2-entry valid/ready buffer. A redirect input from execute, used for branches and jumps, flushes the buffer and any in-flight read.

---
 rtl/inst_fetch_if.sv | 23 ++
 rtl/inst_fetch.sv | 145 ++++++++++++++
 tb/tb_inst_fetch.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Instruction memory read port: fetch stage is master, memory is slave.
// req/addr rise together and are held stable until the cycle ack is high;
// ack may arrive in the same cycle as req, and rdata is taken only on req && ack.
interface inst_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory over a
// variable-latency req/ack port and hands {inst, inst_pc} to decode through
// an output slot plus one skid slot. A redirect flushes both slots; a read
// still in flight when the redirect arrives is drained in FLUSH and dropped.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic               clk,
    input  logic               rst,
    inst_fetch_if.master       imem,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               inst_valid,
    output logic [31:0]        inst,
    output logic [31:0]        inst_pc,
    input  logic               inst_ready,
    output logic [1:0]         state_dbg,
    output logic               skid_valid_dbg,
    output logic [31:0]        skid_pc_dbg
);
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FULL  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state, n_state;
    logic [31:0] pc, n_pc;
    logic [31:0] req_addr, n_req_addr;
    logic        n_inst_valid;
    logic [31:0] n_inst, n_inst_pc;
    logic        skid_valid, n_skid_valid;
    logic [31:0] skid_inst, n_skid_inst;
    logic [31:0] skid_pc, n_skid_pc;

    logic        req;
    logic        ack;
    logic [31:0] target_pc;
    logic        unused_redirect_bits;

    // Request is held through reset low so memory sees the read abandoned.
    assign req            = !rst && (state != FULL);
    assign ack            = req && imem.imem_ack;
    assign imem.imem_req  = req;
    assign imem.imem_addr = req_addr;
    assign target_pc      = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign state_dbg      = state;
    assign skid_valid_dbg = skid_valid;
    assign skid_pc_dbg    = skid_pc;

    // Next-state and next-register values; redirect overrides ack and ready.
    always_comb begin
        n_state      = state;
        n_pc         = pc;
        n_req_addr   = req_addr;
        n_inst_valid = inst_valid;
        n_inst       = inst;
        n_inst_pc    = inst_pc;
        n_skid_valid = skid_valid;
        n_skid_inst  = skid_inst;
        n_skid_pc    = skid_pc;

        if (redirect_valid) begin
            n_inst_valid = 1'b0;
            n_skid_valid = 1'b0;
            n_pc         = target_pc;
            if ((state != FULL) && !ack) begin
                // Pending read must complete at its original address.
                n_state = FLUSH;
            end else begin
                n_state    = FETCH;
                n_req_addr = target_pc;
            end
        end else begin
            // Decode taking the output slot pulls the skid slot forward.
            if (inst_valid && inst_ready) begin
                n_inst_valid = skid_valid;
                n_inst       = skid_inst;
                n_inst_pc    = skid_pc;
                n_skid_valid = 1'b0;
            end
            case (state)
                FETCH: begin
                    if (ack) begin
                        if (!inst_valid || inst_ready) begin
                            n_inst_valid = 1'b1;
                            n_inst       = imem.imem_rdata;
                            n_inst_pc    = req_addr;
                        end else begin
                            n_skid_valid = 1'b1;
                            n_skid_inst  = imem.imem_rdata;
                            n_skid_pc    = req_addr;
                            n_state      = FULL;
                        end
                        n_pc       = req_addr + 32'd4;
                        n_req_addr = req_addr + 32'd4;
                    end
                end
                FULL: begin
                    if (inst_ready) begin
                        n_state = FETCH;
                    end
                end
                FLUSH: begin
                    if (ack) begin
                        n_req_addr = pc;
                        n_state    = FETCH;
                    end
                end
                default: begin
                    n_state = FETCH;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            inst_valid <= 1'b0;
            inst       <= NOP;
            inst_pc    <= 32'h0;
            skid_valid <= 1'b0;
            skid_inst  <= NOP;
            skid_pc    <= 32'h0;
        end else begin
            state      <= n_state;
            pc         <= n_pc;
            req_addr   <= n_req_addr;
            inst_valid <= n_inst_valid;
            inst       <= n_inst;
            inst_pc    <= n_inst_pc;
            skid_valid <= n_skid_valid;
            skid_inst  <= n_skid_inst;
            skid_pc    <= n_skid_pc;
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, streaming, back-pressure, slow
// memory, redirect during a pending read, redirect colliding with ack,
// address wrap and reset while full.
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [1:0]  state_dbg;
    logic        skid_valid_dbg;
    logic [31:0] skid_pc_dbg;

    int vectors     = 0;
    int miscompares = 0;
    int mem_lat     = 0;
    int wait_cnt    = 0;

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_FULL  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    inst_fetch_if imem ();

    inst_fetch #(.RESET_PC(32'h0000_3000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (imem.master),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .state_dbg      (state_dbg),
        .skid_valid_dbg (skid_valid_dbg),
        .skid_pc_dbg    (skid_pc_dbg)
    );

    // clock
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // memory model: ack after mem_lat cycles of a held request
    assign imem.imem_ack   = imem.imem_req && (wait_cnt == mem_lat);
    assign imem.imem_rdata = imem.imem_ack ? mem_word(imem.imem_addr) : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (!imem.imem_req || imem.imem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // leaves the bench in cycle 0 after reset release
    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0; mem_lat = 0;
        step();
        step();
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", inst_valid); end
        vectors++; if (inst !== 32'h0000_0013) begin miscompares++; $display("FAIL reset_inst got %h exp 00000013", inst); end
        vectors++; if (inst_pc !== 32'h0) begin miscompares++; $display("FAIL reset_inst_pc got %h exp 0", inst_pc); end
        vectors++; if (imem.imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b exp 0", imem.imem_req); end
        vectors++; if (imem.imem_addr !== 32'h3000) begin miscompares++; $display("FAIL reset_addr got %h exp 3000", imem.imem_addr); end
        vectors++; if (state_dbg !== S_FETCH) begin miscompares++; $display("FAIL reset_state got %0d exp 0", state_dbg); end
        vectors++; if (skid_valid_dbg !== 1'b0) begin miscompares++; $display("FAIL reset_skid got %b exp 0", skid_valid_dbg); end
        rst = 1'b0;
        #1;
        vectors++; if (imem.imem_req !== 1'b1) begin miscompares++; $display("FAIL first_req got %b exp 1", imem.imem_req); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        mem_lat = 0; inst_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            exp_pc = 32'h3000 + 32'(4 * i);
            vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d] got %b exp 1", i, inst_valid); end
            vectors++; if (inst_pc !== exp_pc) begin miscompares++; $display("FAIL stream_pc[%0d] got %h exp %h", i, inst_pc, exp_pc); end
            vectors++; if (inst !== mem_word(exp_pc)) begin miscompares++; $display("FAIL stream_inst[%0d] got %h exp %h", i, inst, mem_word(exp_pc)); end
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] exp_pc;
        mem_lat = 0; inst_ready = 1'b0;
        do_reset();
        step();  // cycle 1: 0x3000 valid, 0x3004 acked into skid
        vectors++; if (inst_pc !== 32'h3000) begin miscompares++; $display("FAIL bp_first got %h exp 3000", inst_pc); end
        step();  // cycle 2
        vectors++; if (state_dbg !== S_FULL) begin miscompares++; $display("FAIL bp_state got %0d exp 1", state_dbg); end
        vectors++; if (skid_valid_dbg !== 1'b1) begin miscompares++; $display("FAIL bp_skid_valid got %b exp 1", skid_valid_dbg); end
        vectors++; if (skid_pc_dbg !== 32'h3004) begin miscompares++; $display("FAIL bp_skid_pc got %h exp 3004", skid_pc_dbg); end
        vectors++; if (imem.imem_req !== 1'b0) begin miscompares++; $display("FAIL bp_req got %b exp 0", imem.imem_req); end
        for (int c = 3; c <= 5; c++) begin
            step();
            vectors++; if (imem.imem_req !== 1'b0 || inst_pc !== 32'h3000) begin miscompares++; $display("FAIL bp_hold[%0d] req %b pc %h exp req 0 pc 3000", c, imem.imem_req, inst_pc); end
        end
        step();  // cycle 6: release
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'h3000 + 32'(4 * i);
            vectors++; if (inst_valid !== 1'b1 || inst_pc !== exp_pc) begin miscompares++; $display("FAIL bp_drain[%0d] valid %b pc %h exp 1 %h", i, inst_valid, inst_pc, exp_pc); end
            step();
        end
    endtask

    task automatic test_slow_mem();
        logic        exp_v;
        logic [31:0] exp_a;
        mem_lat = 3; inst_ready = 1'b1;
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            exp_v = (c == 4) || (c == 8);
            exp_a = (c < 4) ? 32'h3000 : (c < 8) ? 32'h3004 : 32'h3008;
            vectors++; if (inst_valid !== exp_v) begin miscompares++; $display("FAIL slow_valid[%0d] got %b exp %b", c, inst_valid, exp_v); end
            vectors++; if (imem.imem_addr !== exp_a || imem.imem_req !== 1'b1) begin miscompares++; $display("FAIL slow_addr[%0d] got %h req %b exp %h 1", c, imem.imem_addr, imem.imem_req, exp_a); end
            step();
        end
    endtask

    task automatic test_redirect_flush();
        mem_lat = 2; inst_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 7; c++) step();  // cycle 7: 0x3008 pending
        vectors++; if (imem.imem_addr !== 32'h3008 || imem.imem_ack !== 1'b0) begin miscompares++; $display("FAIL rf_pending addr %h ack %b exp 3008 0", imem.imem_addr, imem.imem_ack); end
        redirect_valid = 1'b1; redirect_pc = 32'h4001;
        step();  // cycle 8
        redirect_valid = 1'b0;
        vectors++; if (state_dbg !== S_FLUSH) begin miscompares++; $display("FAIL rf_state got %0d exp 2", state_dbg); end
        vectors++; if (imem.imem_addr !== 32'h3008) begin miscompares++; $display("FAIL rf_stale_addr got %h exp 3008", imem.imem_addr); end
        for (int c = 8; c < 12; c++) begin
            vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL rf_gap[%0d] got %b exp 0", c, inst_valid); end
            step();
            if (c == 8) begin
                vectors++; if (imem.imem_addr !== 32'h4000) begin miscompares++; $display("FAIL rf_new_addr got %h exp 4000", imem.imem_addr); end
            end
        end
        vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4000) begin miscompares++; $display("FAIL rf_target valid %b pc %h exp 1 4000", inst_valid, inst_pc); end
        vectors++; if (inst !== mem_word(32'h4000)) begin miscompares++; $display("FAIL rf_target_inst got %h exp %h", inst, mem_word(32'h4000)); end
    endtask

    task automatic test_redirect_collision();
        mem_lat = 0; inst_ready = 1'b1;
        do_reset();
        step();
        step();  // cycle 2: 0x3004 on output, 0x3008 acked
        vectors++; if (imem.imem_ack !== 1'b1 || inst_valid !== 1'b1) begin miscompares++; $display("FAIL rc_setup ack %b valid %b exp 1 1", imem.imem_ack, inst_valid); end
        redirect_valid = 1'b1; redirect_pc = 32'h5000;
        step();  // cycle 3
        redirect_valid = 1'b0;
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL rc_flushed got %b exp 0", inst_valid); end
        vectors++; if (state_dbg !== S_FETCH || imem.imem_addr !== 32'h5000) begin miscompares++; $display("FAIL rc_refetch state %0d addr %h exp 0 5000", state_dbg, imem.imem_addr); end
        step();
        vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'h5000) begin miscompares++; $display("FAIL rc_target valid %b pc %h exp 1 5000", inst_valid, inst_pc); end
    endtask

    task automatic test_wrap_and_reset();
        mem_lat = 0; inst_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        step();  // cycle 1
        redirect_valid = 1'b0;
        vectors++; if (inst_valid !== 1'b0 || imem.imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_req valid %b addr %h exp 0 fffffffc", inst_valid, imem.imem_addr); end
        step();  // cycle 2
        vectors++; if (inst_pc !== 32'hFFFF_FFFC || imem.imem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_edge pc %h addr %h exp fffffffc 0", inst_pc, imem.imem_addr); end
        step();  // cycle 3
        vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin miscompares++; $display("FAIL wrap_zero valid %b pc %h exp 1 0", inst_valid, inst_pc); end
        inst_ready = 1'b0;
        step();  // cycle 4: full
        vectors++; if (state_dbg !== S_FULL || skid_pc_dbg !== 32'h4) begin miscompares++; $display("FAIL wrap_full state %0d skid %h exp 1 4", state_dbg, skid_pc_dbg); end
        rst = 1'b1;
        #1;
        vectors++; if (imem.imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req got %b exp 0", imem.imem_req); end
        step();  // cycle 5
        vectors++; if (inst_valid !== 1'b0 || skid_valid_dbg !== 1'b0 || imem.imem_addr !== 32'h3000) begin miscompares++; $display("FAIL rst_mid valid %b skid %b addr %h exp 0 0 3000", inst_valid, skid_valid_dbg, imem.imem_addr); end
        rst = 1'b0; inst_ready = 1'b1;
        #1;
        vectors++; if (imem.imem_req !== 1'b1) begin miscompares++; $display("FAIL rst_rereq got %b exp 1", imem.imem_req); end
        step();
        vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'h3000) begin miscompares++; $display("FAIL rst_refetch valid %b pc %h exp 1 3000", inst_valid, inst_pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_pressure();
        test_slow_mem();
        test_redirect_flush();
        test_redirect_collision();
        test_wrap_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
